// File: rtl/decisecond_stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// decisecond_stopwatch_pkg
// Shared definitions for the decisecond stopwatch:
//   state_t   - stopwatch control states (IDLE, RUN, LAP, PAUSE)
//   DIGIT_W   - width of one BCD digit
//   bcdNext   - next value of a BCD digit with a programmable terminal value
// ---------------------------------------------------------------------------
package decisecond_stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Next value of a BCD digit. Anything at or above the terminal value rolls
  // back to zero, so a digit can never wander into a non-BCD code.
  function automatic logic [DIGIT_W-1:0] bcdNext(
    input logic [DIGIT_W-1:0] digit,
    input logic [DIGIT_W-1:0] terminal,
    input logic               inc
  );
    logic [DIGIT_W-1:0] result;
    result = digit;
    if (inc) begin
      if (digit >= terminal) result = '0;
      else                   result = digit + 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/decisecond_stopwatch_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit of the stopwatch count chain, counting 0..TERMINAL.
// Ports:
//   clk     - system clock
//   resetN  - asynchronous active-low reset (digit -> 0)
//   clear   - synchronous clear, wins over inc
//   inc     - advance the digit by one at the next edge
//   digit   - current digit value
//   carry   - inc while at TERMINAL; drives the next digit's inc
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import decisecond_stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] TERMINAL = 4'd9
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  // Digit register; clear has priority so PAUSE->IDLE always lands on zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else begin
      digit <= bcdNext(digit, TERMINAL, inc);
    end
  end

  assign carry = inc && (digit == TERMINAL);

endmodule

// File: rtl/decisecond_stopwatch.sv
// ---------------------------------------------------------------------------
// decisecond_stopwatch
// Start/stop/lap stopwatch counting tenths of seconds in BCD up to
// MAXMIN:59.9, wrapping to 0:00.0 with a sticky overflow flag.
// Ports:
//   clk          - system clock (100 MHz)
//   resetN       - asynchronous active-low reset
//   decisecond   - one-clock tick every 0.1 s
//   startStop    - debounced one-clock start/stop pulse
//   lapReset     - debounced one-clock lap/reset pulse
//   dispTenths   - displayed tenths digit
//   dispSecOnes  - displayed seconds-ones digit
//   dispSecTens  - displayed seconds-tens digit (0-5)
//   dispMin      - displayed minutes digit (0-MAXMIN)
//   running      - high in RUN or LAP
//   lapActive    - high in LAP (display frozen on the lap latch)
//   overflow     - sticky, set on wrap past MAXMIN:59.9
// ---------------------------------------------------------------------------
module decisecond_stopwatch
  import decisecond_stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAXMIN = 4'd9
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               decisecond,
  input  logic               startStop,
  input  logic               lapReset,
  output logic [DIGIT_W-1:0] dispTenths,
  output logic [DIGIT_W-1:0] dispSecOnes,
  output logic [DIGIT_W-1:0] dispSecTens,
  output logic [DIGIT_W-1:0] dispMin,
  output logic               running,
  output logic               lapActive,
  output logic               overflow
);

  state_t r_state;
  state_t w_nextState;
  logic   w_clear;
  logic   w_latchLap;
  logic   w_count;

  logic [DIGIT_W-1:0] w_liveTenths, w_liveSecOnes, w_liveSecTens, w_liveMin;
  logic               w_carryTenths, w_carrySecOnes, w_carrySecTens, w_wrap;
  logic [DIGIT_W-1:0] r_lapTenths, r_lapSecOnes, r_lapSecTens, r_lapMin;
  logic               r_overflow;

  // Ticks count on the pre-edge state, so a tick arriving with the stop press
  // is counted and one arriving with the start press is not.
  assign w_count = decisecond && ((r_state == RUN) || (r_state == LAP));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // startStop is tested first in every state so it wins over a simultaneous
  // lapReset.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_latchLap  = 1'b0;
    case (r_state)
      IDLE: begin
        if (startStop) w_nextState = RUN;
      end
      RUN: begin
        if (startStop) begin
          w_nextState = PAUSE;
        end else if (lapReset) begin
          w_nextState = LAP;
          w_latchLap  = 1'b1;
        end
      end
      LAP: begin
        if (startStop)     w_nextState = PAUSE;
        else if (lapReset) w_nextState = RUN;
      end
      PAUSE: begin
        if (startStop) begin
          w_nextState = RUN;
        end else if (lapReset) begin
          w_nextState = IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  bcd_digit_counter #(.TERMINAL(4'd9)) uTenths (
    .clk(clk), .resetN(resetN), .clear(w_clear), .inc(w_count),
    .digit(w_liveTenths), .carry(w_carryTenths)
  );

  bcd_digit_counter #(.TERMINAL(4'd9)) uSecOnes (
    .clk(clk), .resetN(resetN), .clear(w_clear), .inc(w_carryTenths),
    .digit(w_liveSecOnes), .carry(w_carrySecOnes)
  );

  bcd_digit_counter #(.TERMINAL(4'd5)) uSecTens (
    .clk(clk), .resetN(resetN), .clear(w_clear), .inc(w_carrySecOnes),
    .digit(w_liveSecTens), .carry(w_carrySecTens)
  );

  bcd_digit_counter #(.TERMINAL(MAXMIN)) uMin (
    .clk(clk), .resetN(resetN), .clear(w_clear), .inc(w_carrySecTens),
    .digit(w_liveMin), .carry(w_wrap)
  );

  // The lap latch captures the post-edge live count, so a tick landing on the
  // lap press is included in the frozen value.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lapTenths  <= '0;
      r_lapSecOnes <= '0;
      r_lapSecTens <= '0;
      r_lapMin     <= '0;
    end else if (w_clear) begin
      r_lapTenths  <= '0;
      r_lapSecOnes <= '0;
      r_lapSecTens <= '0;
      r_lapMin     <= '0;
    end else if (w_latchLap) begin
      r_lapTenths  <= bcdNext(w_liveTenths,  4'd9,   w_count);
      r_lapSecOnes <= bcdNext(w_liveSecOnes, 4'd9,   w_carryTenths);
      r_lapSecTens <= bcdNext(w_liveSecTens, 4'd5,   w_carrySecOnes);
      r_lapMin     <= bcdNext(w_liveMin,     MAXMIN, w_carrySecTens);
    end
  end

  // Sticky overflow: set by the carry out of the minutes digit, dropped only
  // by reset or the PAUSE->IDLE clear (which can never coincide with a tick).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     r_overflow <= 1'b0;
    else if (w_clear) r_overflow <= 1'b0;
    else if (w_wrap)  r_overflow <= 1'b1;
  end

  assign lapActive   = (r_state == LAP);
  assign running     = (r_state == RUN) || (r_state == LAP);
  assign overflow    = r_overflow;
  assign dispTenths  = lapActive ? r_lapTenths  : w_liveTenths;
  assign dispSecOnes = lapActive ? r_lapSecOnes : w_liveSecOnes;
  assign dispSecTens = lapActive ? r_lapSecTens : w_liveSecTens;
  assign dispMin     = lapActive ? r_lapMin     : w_liveMin;

endmodule

// File: doc/decisecond_stopwatch.md
Name: decisecond_stopwatch

Overview:
Consumer of the board's one-clock-wide decisecond tick: a start/stop/lap stopwatch counting tenths of seconds in BCD up to M:59.9. It sits between the decisecond pace generator and the seven-segment display driver, taking debounced single-cycle button pulses. Provides a live or lap-frozen digit set plus status flags.

Parameters:
MAXMIN, 4'd9, terminal value of the minutes digit; count wraps from MAXMIN:59.9 to 0:00.0.

Ports:
clk  input  1  system clock, 100 MHz
resetN  input  1  asynchronous active-low reset
decisecond  input  1  one-clk-wide tick, one per 0.1 s
startStop  input  1  debounced one-clk pulse, start/stop button
lapReset  input  1  debounced one-clk pulse, lap/reset button
dispTenths  output  4  BCD tenths digit shown
dispSecOnes  output  4  BCD seconds-ones digit shown
dispSecTens  output  4  BCD seconds-tens digit shown (0-5)
dispMin  output  4  BCD minutes digit shown (0-MAXMIN)
running  output  1  high in RUN or LAP
lapActive  output  1  high in LAP (display frozen)
overflow  output  1  sticky, set on wrap past MAXMIN:59.9

Behaviour:
- Reset (resetN low, async): state IDLE, live count 0:00.0, lap latch 0:00.0, overflow 0; all outputs 0.
- States: IDLE, RUN, LAP, PAUSE; registered, advance on posedge clk.
- IDLE: startStop -> RUN; lapReset ignored.
- RUN: startStop -> PAUSE; lapReset -> LAP, latching the live count (including any increment made at that same edge).
- LAP: startStop -> PAUSE (freeze released); lapReset -> RUN (freeze released).
- PAUSE: startStop -> RUN; lapReset -> IDLE, clearing live count, lap latch and overflow.
- startStop and lapReset in the same cycle: startStop acts, lapReset is ignored.
- Counting: live count increments at an edge where decisecond=1 and the current (pre-edge) state is RUN or LAP. A tick in the cycle of a start/stop press is governed by the pre-edge state: counted when stopping, not counted when starting.
- BCD chain: tenths 0-9, secOnes 0-9, secTens 0-5, min 0-MAXMIN; each digit increments when all lower digits are at their terminal value. Digits never hold non-BCD values.
- Wrap: MAXMIN:59.9 + tick -> 0:00.0 at the same edge overflow is set; overflow stays 1 until reset or PAUSE->IDLE.
- Display: lap latch in LAP, live count otherwise. Selection is combinational from registers: a counted tick is visible right after its edge; a lap freeze/release is visible the cycle after the button edge.
- The live count keeps advancing during LAP. Ticks wider than one clock are out of contract: each high cycle counts.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3) and BCD digit width constant (4).
- Sub-module bcd_digit_counter: parameter TERMINAL, inputs clk/resetN/clear/inc, outputs digit[3:0] and carry (= inc && digit==TERMINAL). Four instances, chained by carry.

Test Plan:
- Reset mid-run: RUN at 0:03.7, pull resetN low between edges -> all outputs 0 immediately; after release, state IDLE, ticks do not count.
- Basic count: startStop, then 125 ticks one every 4 clks -> display 0:12.5, running=1; startStop -> running=0, further ticks leave 0:12.5.
- Lap: RUN at 0:05.0, lapReset, 30 ticks -> display 0:05.0, lapActive=1; lapReset -> display 0:08.0, lapActive=0.
- Simultaneous: startStop, lapReset and decisecond high together in RUN at 0:01.9 -> state PAUSE, live count 0:02.0, no LAP.
- Wrap: MAXMIN=1, run 1200 ticks from 0:00.0 -> display 0:00.0, overflow=1; PAUSE then lapReset -> IDLE, overflow=0.
- Digit carry: from 0:09.9 one tick -> 0:10.0; from 0:59.9 one tick -> 1:00.0.
